// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus responder: instruction opcodes, FSM state
// encoding, the space character, and the decode/index-step helpers.
package lcd_pkg;

    localparam logic [7:0] OP_CLEAR    = 8'h01;
    localparam logic [7:0] OP_HOME     = 8'h02;
    localparam logic [7:0] OP_ENTRY    = 8'h04;
    localparam logic [7:0] OP_DISPLAY  = 8'h08;
    localparam logic [7:0] OP_SHIFT    = 8'h10;
    localparam logic [7:0] OP_FUNCTION = 8'h20;
    localparam logic [7:0] OP_CGRAM    = 8'h40;
    localparam logic [7:0] OP_DDRAM    = 8'h80;

    localparam logic [7:0] SPACE_CHAR  = 8'h20;
    localparam int         BUF_DEPTH   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        INS_NONE,
        INS_CLEAR,
        INS_HOME,
        INS_ENTRY,
        INS_DISPLAY,
        INS_SHIFT,
        INS_FUNCTION,
        INS_CGRAM,
        INS_DDRAM
    } instr_e;

    // Instructions are classified by their highest set bit, so a threshold
    // compare against each opcode is enough.
    function automatic instr_e decode_instr(input logic [7:0] op);
        if (op >= OP_DDRAM)         return INS_DDRAM;
        else if (op >= OP_CGRAM)    return INS_CGRAM;
        else if (op >= OP_FUNCTION) return INS_FUNCTION;
        else if (op >= OP_SHIFT)    return INS_SHIFT;
        else if (op >= OP_DISPLAY)  return INS_DISPLAY;
        else if (op >= OP_ENTRY)    return INS_ENTRY;
        else if (op >= OP_HOME)     return INS_HOME;
        else if (op == OP_CLEAR)    return INS_CLEAR;
        else                        return INS_NONE;
    endfunction

    // With the {line, column} index layout, plain 5-bit wrap-around gives the
    // 15->16, 31->0, 16->15 and 0->31 transitions directly.
    function automatic logic [4:0] step_idx(input logic [4:0] idx, input logic inc);
        return inc ? idx + 5'd1 : idx - 5'd1;
    endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus plus a rising-edge strobe
// on the synchronized enable.
module lcd_bus_sync #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rs,
    input  logic                 rw,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 en_s,
    output logic                 rs_s,
    output logic                 rw_s,
    output logic [DATA_BITS-1:0] data_s,
    output logic                 en_rise
);

    localparam int W = DATA_BITS + 3;

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic         en_prev_q, en_prev_d;

    always_comb begin
        meta_d    = {enable, rs, rw, data_in};
        sync_d    = meta_q;
        en_prev_d = sync_q[W-1];
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q    <= '0;
            sync_q    <= '0;
            en_prev_q <= 1'b0;
        end else begin
            meta_q    <= meta_d;
            sync_q    <= sync_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign {en_s, rs_s, rw_s, data_s} = sync_q;
    assign en_rise = en_s & ~en_prev_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder with a 32-byte character buffer.
// Define LCD_RESP_READBACK_EN to enable rw=1 reads (busy/address and data).
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int BUSY_CYCLES = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs,
    input  logic                 rw,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_oe,
    output logic                 busy,
    input  logic [4:0]           rd_idx,
    output logic [7:0]           rd_char,
    output logic                 display_on,
    output logic                 cursor_on,
    output logic                 entry_inc,
    output logic                 two_line,
    output logic                 frame_done
);

    localparam int               CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

    logic                 en_s, rs_s, rw_s, en_rise;
    logic [DATA_BITS-1:0] data_s;

    lcd_bus_sync #(.DATA_BITS(DATA_BITS)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .rs      (rs),
        .rw      (rw),
        .data_in (data_in),
        .en_s    (en_s),
        .rs_s    (rs_s),
        .rw_s    (rw_s),
        .data_s  (data_s),
        .en_rise (en_rise)
    );

    state_e           state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [4:0]       clr_cnt_q, clr_cnt_d;
    logic             display_on_q, display_on_d;
    logic             cursor_on_q, cursor_on_d;
    logic             entry_inc_q, entry_inc_d;
    logic             two_line_q, two_line_d;
    logic             frame_done_q, frame_done_d;
    instr_e           instr;

    logic [7:0]       char_buf_q [BUF_DEPTH];
    logic             buf_we;
    logic [4:0]       buf_waddr;
    logic [7:0]       buf_wdata;

`ifdef LCD_RESP_READBACK_EN
    logic             rd_active_q, rd_active_d;
    logic             rd_rs_q, rd_rs_d;
`endif

    // NOTE: every variable gets its hold value first, so no path through the
    // block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        busy_cnt_d   = busy_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        display_on_d = display_on_q;
        cursor_on_d  = cursor_on_q;
        entry_inc_d  = entry_inc_q;
        two_line_d   = two_line_q;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        buf_waddr    = idx_q;
        buf_wdata    = data_s[7:0];
        instr        = decode_instr(data_s[7:0]);

        unique case (state_q)
            ST_IDLE: begin
                if (en_rise && !rw_s) begin
                    state_d    = ST_EXEC;
                    busy_cnt_d = CNT_LOAD;
                    if (rs_s) begin
                        buf_we       = 1'b1;
                        idx_d        = step_idx(idx_q, entry_inc_q);
                        frame_done_d = entry_inc_q && (idx_q == 5'd31);
                    end else begin
                        case (instr)
                            INS_CLEAR: begin
                                state_d   = ST_CLEAR;
                                clr_cnt_d = '0;
                            end
                            INS_HOME:     idx_d = '0;
                            INS_ENTRY:    entry_inc_d = data_s[1];
                            INS_DISPLAY: begin
                                display_on_d = data_s[2];
                                cursor_on_d  = data_s[1];
                            end
                            INS_FUNCTION: two_line_d = data_s[3];
                            INS_DDRAM:    idx_d = {data_s[6], data_s[3:0]};
                            default: ;
                        endcase
                    end
                end
            end
            ST_EXEC: begin
                if (busy_cnt_q == '0) state_d = ST_IDLE;
                else                  busy_cnt_d = busy_cnt_q - CNT_W'(1);
            end
            ST_CLEAR: begin
                buf_we    = 1'b1;
                buf_waddr = clr_cnt_q;
                buf_wdata = SPACE_CHAR;
                if (clr_cnt_q == 5'd31) begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    entry_inc_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef LCD_RESP_READBACK_EN
        rd_active_d = rd_active_q;
        rd_rs_d     = rd_rs_q;
        if (en_rise && rw_s) begin
            rd_active_d = 1'b1;
            rd_rs_d     = rs_s;
        end else if (rd_active_q && !en_s) begin
            // A data read advances the address once the initiator releases enable.
            rd_active_d = 1'b0;
            if (rd_rs_q && state_q != ST_CLEAR) idx_d = step_idx(idx_q, entry_inc_q);
        end
`endif

        // Reset aborts a clear mid-way and leaves the buffer as it stands.
        if (!rst_n) buf_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            busy_cnt_q   <= '0;
            clr_cnt_q    <= '0;
            display_on_q <= 1'b0;
            cursor_on_q  <= 1'b0;
            entry_inc_q  <= 1'b1;
            two_line_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_cnt_q   <= busy_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            display_on_q <= display_on_d;
            cursor_on_q  <= cursor_on_d;
            entry_inc_q  <= entry_inc_d;
            two_line_q   <= two_line_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the character buffer is deliberately left out of reset; filling it
    // is the CLEAR instruction's job, and a plain RAM maps better without it.
    always_ff @(posedge clk) begin
        if (buf_we) char_buf_q[buf_waddr] <= buf_wdata;
    end

    assign busy       = (state_q != ST_IDLE);
    assign rd_char    = char_buf_q[rd_idx];
    assign display_on = display_on_q;
    assign cursor_on  = cursor_on_q;
    assign entry_inc  = entry_inc_q;
    assign two_line   = two_line_q;
    assign frame_done = frame_done_q;

`ifdef LCD_RESP_READBACK_EN
    logic [6:0] ac;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_active_q <= 1'b0;
            rd_rs_q     <= 1'b0;
        end else begin
            rd_active_q <= rd_active_d;
            rd_rs_q     <= rd_rs_d;
        end
    end

    assign ac       = {idx_q[4], 2'b00, idx_q[3:0]};
    assign data_oe  = rd_active_q;
    assign data_out = !rd_active_q ? '0 :
                      rd_rs_q      ? DATA_BITS'(char_buf_q[idx_q]) :
                                     DATA_BITS'({busy, ac});
`else
    logic unused_en_s;

    assign unused_en_s = en_s;
    assign data_oe     = 1'b0;
    assign data_out    = '0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: directed scenarios plus random
// traffic checked against a transaction-level model of the display controller.
module tb_lcd_bus_responder;
    import lcd_pkg::*;

    localparam int DATA_BITS   = 8;
    localparam int BUSY_CYCLES = 40;

    logic       clk = 1'b0;
    logic       rst_n, rs, rw, enable;
    logic [7:0] data_in, data_out;
    logic       data_oe, busy;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;
    logic       display_on, cursor_on, entry_inc, two_line, frame_done;

    always #5 clk = ~clk;

    lcd_bus_responder #(.DATA_BITS(DATA_BITS), .BUSY_CYCLES(BUSY_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs         (rs),
        .rw         (rw),
        .enable     (enable),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .busy       (busy),
        .rd_idx     (rd_idx),
        .rd_char    (rd_char),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .entry_inc  (entry_inc),
        .two_line   (two_line),
        .frame_done (frame_done)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitors, sampled on the falling edge.
    int fd_count      = 0;
    int busy_run      = 0;
    int last_busy_run = 0;
    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (busy) busy_run++;
        else if (busy_run != 0) begin
            last_busy_run = busy_run;
            busy_run      = 0;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: the display as seen by a programmer.
    logic [7:0] m_buf   [32];
    bit         m_known [32];
    int         m_idx;
    bit         m_disp, m_cur, m_inc, m_two;
    int         m_fd;

    task automatic model_reset();
        m_idx  = 0;
        m_disp = 0;
        m_cur  = 0;
        m_inc  = 1;
        m_two  = 0;
    endtask

    task automatic model_instr(input logic [7:0] b);
        if (b >= 8'h80)      m_idx = (b[6] ? 16 : 0) + int'(b[3:0]);
        else if (b >= 8'h40) ;
        else if (b >= 8'h20) m_two = b[3];
        else if (b >= 8'h10) ;
        else if (b >= 8'h08) begin
            m_disp = b[2];
            m_cur  = b[1];
        end
        else if (b >= 8'h04) m_inc = b[1];
        else if (b >= 8'h02) m_idx = 0;
        else if (b == 8'h01) begin
            for (int i = 0; i < 32; i++) begin
                m_buf[i]   = 8'h20;
                m_known[i] = 1;
            end
            m_idx = 0;
            m_inc = 1;
        end
    endtask

    task automatic model_data(input logic [7:0] b);
        m_buf[m_idx]   = b;
        m_known[m_idx] = 1;
        if (m_inc) begin
            if (m_idx == 31) begin
                m_idx = 0;
                m_fd++;
            end else m_idx++;
        end else begin
            m_idx = (m_idx == 0) ? 31 : m_idx - 1;
        end
    endtask

    // Bus transaction: data set up before enable, enable held long enough to
    // be seen through the synchronizer, then released.
    task automatic bus_cycle(input logic rs_v, input logic rw_v, input logic [7:0] d);
        @(negedge clk);
        rs      = rs_v;
        rw      = rw_v;
        data_in = d;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic bus_read(input logic rs_v, output logic [7:0] dout, output logic oe);
        @(negedge clk);
        rs = rs_v;
        rw = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        dout   = data_out;
        oe     = data_oe;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_instr(input logic [7:0] b);
        bus_cycle(1'b0, 1'b0, b);
        model_instr(b);
        wait_idle();
    endtask

    task automatic send_data(input logic [7:0] b);
        bus_cycle(1'b1, 1'b0, b);
        model_data(b);
        wait_idle();
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_disp"}, display_on, m_disp);
        check({tag, "_cur"},  cursor_on,  m_cur);
        check({tag, "_inc"},  entry_inc,  m_inc);
        check({tag, "_two"},  two_line,   m_two);
        check({tag, "_idx"},  dut.idx_q,  m_idx);
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 32; i++) begin
            if (m_known[i]) begin
                rd_idx = 5'(i);
                #1;
                check($sformatf("%s[%0d]", tag, i), rd_char, m_buf[i]);
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] last_b;
        logic [7:0] rd_val;
        logic       rd_oe;
        int         fd0;
        int         idx0;
        string      hora;

        rs = 0; rw = 0; enable = 0; data_in = '0; rd_idx = '0; rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_known[i] = 0;
        m_fd = 0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_busy",       busy,        1'b0);
        check("rst_data_oe",    data_oe,     1'b0);
        check("rst_data_out",   data_out,    8'h00);
        check("rst_frame_done", frame_done,  1'b0);
        check("rst_display_on", display_on,  1'b0);
        check("rst_cursor_on",  cursor_on,   1'b0);
        check("rst_entry_inc",  entry_inc,   1'b1);
        check("rst_two_line",   two_line,    1'b0);
        check("rst_idx",        dut.idx_q,   5'd0);
        check("rst_state",      32'(dut.state_q), 32'(ST_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Initialisation sequence ending in a clear.
        send_instr(8'h38);
        check("exec_busy_len", last_busy_run, BUSY_CYCLES);
        send_instr(8'h06);
        send_instr(8'h0C);
        send_instr(8'h01);
        check("clear_busy_ge32", 32'(last_busy_run >= 32), 1);
        check("init_two_line",   two_line,   1'b1);
        check("init_entry_inc",  entry_inc,  1'b1);
        check("init_display_on", display_on, 1'b1);
        check("init_cursor_on",  cursor_on,  1'b0);
        check_flags("init");
        check_buf("clear_buf");

        // "Hora" at the start of line 1.
        hora = "Hora";
        send_instr(8'h80);
        for (int i = 0; i < 4; i++) send_data(8'(hora[i]));
        check("hora_idx", dut.idx_q, 5'd4);
        check_buf("hora_buf");

        // Line 2 fill: frame_done only on the 31->0 wrap.
        send_instr(8'hC0);
        fd0 = fd_count;
        for (int i = 0; i < 15; i++) send_data(8'($urandom_range(33, 126)));
        check("fd_before_16th", fd_count - fd0, 0);
        send_data(8'($urandom_range(33, 126)));
        check("fd_after_16th", fd_count - fd0, 1);
        check("line2_idx", dut.idx_q, 5'd0);
        check_buf("line2_buf");

        // 17 bytes from line 1 start: the 17th crosses to index 16.
        send_instr(8'h80);
        last_b = '0;
        for (int i = 0; i < 17; i++) begin
            last_b = 8'($urandom_range(33, 126));
            send_data(last_b);
        end
        rd_idx = 5'd16;
        #1;
        check("byte17_at_16", rd_char, last_b);
        check("byte17_idx", dut.idx_q, 5'd17);

        // A write during busy is dropped and does not extend busy.
        bus_cycle(1'b0, 1'b0, 8'h85);
        model_instr(8'h85);
        check("busy_before_drop", busy, 1'b1);
        bus_cycle(1'b1, 1'b0, 8'h41);
        wait_idle();
        check("drop_busy_len", last_busy_run, BUSY_CYCLES);
        check("drop_idx", dut.idx_q, 5'd5);
        check_buf("drop_buf");

        // Decrement mode wraps 0 -> 31 without a frame pulse.
        fd0 = fd_count;
        send_instr(8'h04);
        send_instr(8'h80);
        send_data(8'h5A);
        send_data(8'h5B);
        check("dec_idx", dut.idx_q, 5'd30);
        check("dec_no_fd", fd_count - fd0, 0);
        send_instr(8'h06);

        // Random traffic against the model.
        for (int t = 0; t < 80; t++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) send_instr(b);
            else                           send_data(b);
            check($sformatf("rand_idx_%0d", t), dut.idx_q, m_idx);
        end
        check_flags("rand");
        check("rand_fd", fd_count, m_fd);
        check_buf("rand_buf");

`ifdef LCD_RESP_READBACK_EN
        send_instr(8'hC5);
        bus_read(1'b0, rd_val, rd_oe);
        check("rb_ac_data", rd_val, 8'h45);
        check("rb_ac_oe",   rd_oe,  1'b1);
        check("rb_oe_after", data_oe, 1'b0);
        send_instr(8'h80);
        send_data(8'($urandom_range(33, 126)));
        send_instr(8'h80);
        bus_read(1'b1, rd_val, rd_oe);
        check("rb_char_data", rd_val, m_buf[0]);
        check("rb_char_oe",   rd_oe,  1'b1);
        check("rb_char_idx",  dut.idx_q, 5'd1);
        m_idx = 1;
`else
        idx0 = int'(dut.idx_q);
        check("nrb_idx_model", idx0, m_idx);
        bus_read(1'b0, rd_val, rd_oe);
        check("nrb_data", rd_val, 8'h00);
        check("nrb_oe",   rd_oe,  1'b0);
        check("nrb_busy", busy,   1'b0);
        bus_read(1'b1, rd_val, rd_oe);
        check("nrb_idx",  dut.idx_q, m_idx);
        check("nrb_busy2", busy, 1'b0);
`endif

        // Reset in the middle of a clear.
        bus_cycle(1'b0, 1'b0, 8'h01);
        repeat (5) @(negedge clk);
        check("clear_running", busy, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midclr_busy",  busy, 1'b0);
        check("midclr_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("midclr_idx",   dut.idx_q, 5'd0);
        check("midclr_inc",   entry_inc, 1'b1);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 32; i++) m_known[i] = 0;
        repeat (3) @(negedge clk);
        check("postrst_busy", busy, 1'b0);
        send_instr(8'h01);
        check_flags("reclear");
        check_buf("reclear_buf");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, LCD bus data width.
REQ-002 SHALL have parameter BUSY_CYCLES, default 40, clk cycles that busy stays high after any non-clear instruction.
REQ-003 SHALL have port clk  in  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have ports rs, rw, enable  in  1 each  LCD bus controls, asynchronous to clk.
REQ-006 SHALL have port data_in  in  DATA_BITS  LCD bus data from the initiator.
REQ-007 SHALL have port data_out  out  DATA_BITS  read-back data.
REQ-008 SHALL have port data_oe  out  1  read-back drive enable.
REQ-009 SHALL have port busy  out  1  instruction in progress.
REQ-010 SHALL have ports rd_idx  in  5  and rd_char  out  8  combinational view of the 32-byte character buffer.
REQ-011 SHALL have ports display_on, cursor_on, entry_inc, two_line  out  1 each  decoded mode flags.
REQ-012 SHALL have port frame_done  out  1  one-cycle pulse when the address index wraps from 31 to 0 on a data write.

Function
REQ-013 SHALL pass enable, rs, rw and data_in through a 2-flop synchronizer and latch a transaction on the rising edge of synchronized enable, because the initiator changes data at the falling edge.
REQ-014 SHALL map the DDRAM address to the 5-bit index {addr[6], addr[3:0]}: 0x00-0x0F to 0-15 and 0x40-0x4F to 16-31.
REQ-015 SHALL, on an rs=1, rw=0 write, store data_in at buf[idx] and then step idx by +1 (entry_inc=1) or -1, wrapping 15->16, 31->0, 16->15 and 0->31.
REQ-016 SHALL decode an rs=0, rw=0 write by its highest set bit: 0x01 clear; 0x02/0x03 home (idx=0); 0x04-0x07 entry_inc=bit1; 0x08-0x0F display_on=bit2, cursor_on=bit1; 0x20-0x3F two_line=bit3; 0x80-0xFF set idx from bit 6 and bits 3:0.
REQ-017 SHALL ignore 0x10-0x1F (shift) except that it starts busy.
REQ-018 SHALL use an FSM with states IDLE, EXEC and CLEAR: IDLE->EXEC on any latched non-clear instruction; IDLE->CLEAR on 0x01; EXEC->IDLE after BUSY_CYCLES cycles; CLEAR->IDLE after writing 0x20 to all 32 entries, one per cycle, then setting idx=0 and entry_inc=1.
REQ-019 SHALL hold busy high in EXEC and CLEAR and low in IDLE.
REQ-020 SHALL drop any write latched while busy=1 with no state change.
REQ-021 SHALL treat data writes as instructions for busy purposes (IDLE->EXEC).
REQ-022 SHALL, on an rw=1 transaction while synchronized enable is high, assert data_oe and drive data_out={busy, ac[6:0]} for rs=0, where ac = {idx[4], 2'b00, idx[3:0]}, or buf[idx] for rs=1.
REQ-023 SHALL advance idx at the enable edge that ends an rs=1 read.
REQ-024 SHALL pulse frame_done only on a write-driven 31->0 wrap, not on clear, home or set-address.

Reset
REQ-025 SHALL, with rst_n=0 at posedge clk, force state IDLE, idx=0, busy=0, data_oe=0, data_out=0, frame_done=0, display_on=0, cursor_on=0, entry_inc=1, two_line=0 and synchronizers to 0.
REQ-026 SHALL leave buffer contents undefined after reset.
REQ-027 SHALL abort a CLEAR or EXEC in progress when reset is asserted mid-operation, and the partially cleared buffer SHALL be left as is.

Configuration
REQ-028 SHALL, with LCD_RESP_READBACK_EN defined, implement REQ-022 and REQ-023.
REQ-029 SHALL, without LCD_RESP_READBACK_EN, tie data_oe and data_out to 0 and ignore rw=1 transactions entirely (no idx change, no busy).

Structure
REQ-030 SHALL place the instruction opcode constants, the FSM state encoding and the space code 0x20 in shared package lcd_pkg.
REQ-031 SHALL use one sub-module, lcd_bus_sync, holding the 2-flop synchronizer and the rising-edge strobe.

Verification
REQ-032 SHALL verify: send 0x38, 0x06, 0x0C, 0x01 -> two_line=1, entry_inc=1, display_on=1, cursor_on=0, busy high for 32+ cycles after 0x01, all rd_char=0x20.
REQ-033 SHALL verify: send 0x80 then "Hora" -> buf[0..3]=0x48,0x6F,0x72,0x61, idx=4.
REQ-034 SHALL verify: send 0xC0 then 16 data bytes -> writes land at 16-31, frame_done pulses once after the 16th byte, idx=0.
REQ-035 SHALL verify: 17 data bytes from 0x80 -> 17th byte lands at index 16.
REQ-036 SHALL verify: write 0x41 during busy -> buffer unchanged, idx unchanged.
REQ-037 SHALL verify: with LCD_RESP_READBACK_EN, rs=0 rw=1 after 0xC5 with busy clear -> data_out=0x45, data_oe=1; assert rst_n=0 mid-CLEAR -> busy=0 and state IDLE next cycle.
